// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the pipeline hazard controller
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    BR_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_t;

  localparam int REG_WIDTH_DEF = 5;
  localparam logic [REG_WIDTH_DEF-1:0] X0 = '0;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// rtl/pipe_hazard_ctrl_sat_counter.sv - saturating event counter
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Sticks at all-ones so long runs never wrap back to small values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush controller for the 5-stage RV32 pipeline
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_WIDTH = REG_WIDTH_DEF,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_WIDTH-1:0] ifid_rs1,
  input  logic [REG_WIDTH-1:0] ifid_rs2,
  input  logic [REG_WIDTH-1:0] idex_rd,
  input  logic                 idex_memread,
  input  logic                 idex_branch,
  input  logic                 exmem_branch,
  input  logic                 exmem_taken,
  input  logic                 dmem_req,
  input  logic                 dmem_ready,
  output logic                 pc_en,
  output logic                 pc_sel_target,
  output logic                 ifid_write,
  output logic                 ifid_flush,
  output logic                 idex_bubble,
  output logic                 pipe_hold,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  hz_state_t state, state_next;
  hz_state_t ret_state, ret_next;
  hz_state_t eff_state;
  logic      mem_wait;
  logic      load_use;
  logic      flush_evt;

  // Once in MEM_WAIT, the pipe behaves as the interrupted state on release.
  assign eff_state = (state == MEM_WAIT) ? ret_state : state;
  assign mem_wait  = (state == MEM_WAIT) ? !dmem_ready : (dmem_req && !dmem_ready);
  assign load_use  = idex_memread && (idex_rd != REG_WIDTH'(X0)) &&
                     ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      ret_state <= RUN;
    end else begin
      state     <= state_next;
      ret_state <= ret_next;
    end
  end

  always_comb begin
    pc_en         = 1'b1;
    pc_sel_target = 1'b0;
    ifid_write    = 1'b1;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;
    pipe_hold     = 1'b0;
    flush_evt     = 1'b0;
    state_next    = RUN;
    ret_next      = ret_state;

    if (mem_wait) begin
      pc_en      = 1'b0;
      ifid_write = 1'b0;
      pipe_hold  = 1'b1;
      ret_next   = eff_state;
      state_next = MEM_WAIT;
    end else if (eff_state == BR_WAIT) begin
      if (exmem_branch && exmem_taken) begin
        pc_sel_target = 1'b1;
        ifid_flush    = 1'b1;
        idex_bubble   = 1'b1;
        flush_evt     = 1'b1;
      end else if (!exmem_branch) begin
        pc_en       = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        state_next  = BR_WAIT;
      end
    end else if (idex_branch) begin
      pc_en       = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      state_next  = BR_WAIT;
    end else if (load_use) begin
      pc_en       = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end

    if (reset) begin
      pc_en         = 1'b1;
      pc_sel_target = 1'b0;
      ifid_write    = 1'b1;
      ifid_flush    = 1'b0;
      idex_bubble   = 1'b0;
      pipe_hold     = 1'b0;
      flush_evt     = 1'b0;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (!pc_en),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_evt),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] ifid_rs1, ifid_rs2, idex_rd;
  logic       idex_memread, idex_branch, exmem_branch, exmem_taken;
  logic       dmem_req, dmem_ready;

  logic        pc_en, pc_sel_target, ifid_write, ifid_flush, idex_bubble, pipe_hold;
  logic [15:0] stall_cnt, flush_cnt;
  logic        pc_en4, pc_sel_target4, ifid_write4, ifid_flush4, idex_bubble4, pipe_hold4;
  logic [3:0]  stall_cnt4, flush_cnt4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .idex_rd(idex_rd),
    .idex_memread(idex_memread), .idex_branch(idex_branch),
    .exmem_branch(exmem_branch), .exmem_taken(exmem_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .pc_sel_target(pc_sel_target), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .pipe_hold(pipe_hold),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .idex_rd(idex_rd),
    .idex_memread(idex_memread), .idex_branch(idex_branch),
    .exmem_branch(exmem_branch), .exmem_taken(exmem_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en4), .pc_sel_target(pc_sel_target4), .ifid_write(ifid_write4),
    .ifid_flush(ifid_flush4), .idex_bubble(idex_bubble4), .pipe_hold(pipe_hold4),
    .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Packs {pc_en, pc_sel_target, ifid_write, ifid_flush, idex_bubble, pipe_hold}.
  function automatic int ctl();
    return {26'd0, pc_en, pc_sel_target, ifid_write, ifid_flush, idex_bubble, pipe_hold};
  endfunction

  localparam int NORMAL = 6'b101000;
  localparam int STALL  = 6'b001010 & 6'b000010;
  localparam int HOLD   = 6'b000001;
  localparam int FLUSH  = 6'b111110;

  task automatic idle();
    ifid_rs1 = 0; ifid_rs2 = 0; idex_rd = 0;
    idex_memread = 0; idex_branch = 0; exmem_branch = 0; exmem_taken = 0;
    dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous pulse between clock edges.
  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    #1;
    check("reset_ctl", ctl(), NORMAL);
    check("reset_stall_cnt", stall_cnt, 0);
    idex_memread = 1; idex_rd = 5; ifid_rs2 = 5;
    #1;
    check("reset_forces_normal", ctl(), NORMAL);
    idle();
    tick(); tick();
    reset = 1'b0;

    // load-use
    idex_memread = 1; idex_rd = 5; ifid_rs2 = 5;
    #1;
    check("loaduse_ctl", ctl(), STALL);
    tick();
    idle();
    #1;
    check("loaduse_next_ctl", ctl(), NORMAL);
    check("loaduse_stall_cnt", stall_cnt, 1);

    // x0 load never stalls
    idex_memread = 1; idex_rd = 0; ifid_rs1 = 0;
    #1;
    check("x0_ctl", ctl(), NORMAL);
    tick();
    idle();
    check("x0_stall_cnt", stall_cnt, 1);

    // taken branch
    pulse_reset();
    idex_branch = 1;
    idex_memread = 1; idex_rd = 3; ifid_rs1 = 3;
    #1;
    check("br_ex_ctl", ctl(), STALL);
    tick();
    idle();
    exmem_branch = 1; exmem_taken = 1;
    #1;
    check("br_taken_ctl", ctl(), FLUSH);
    tick();
    idle();
    #1;
    check("br_after_ctl", ctl(), NORMAL);
    check("br_flush_cnt", flush_cnt, 1);
    check("br_stall_cnt", stall_cnt, 1);

    // not-taken branch delayed by a memory wait
    pulse_reset();
    idex_branch = 1;
    tick();
    idle();
    dmem_req = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("memwait_ctl%0d", i), ctl(), HOLD);
      tick();
    end
    dmem_ready = 1; exmem_branch = 1; exmem_taken = 0;
    #1;
    check("nt_release_ctl", ctl(), NORMAL);
    tick();
    idle();
    #1;
    check("nt_run_ctl", ctl(), NORMAL);
    check("nt_stall_cnt", stall_cnt, 4);
    check("nt_flush_cnt", flush_cnt, 0);

    // zero-wait access, mem wait over load-use, resolve ignored in RUN
    dmem_req = 1; dmem_ready = 1;
    #1;
    check("zero_wait_ctl", ctl(), NORMAL);
    dmem_ready = 0; idex_memread = 1; idex_rd = 7; ifid_rs1 = 7;
    #1;
    check("memwait_over_loaduse", ctl(), HOLD);
    idle();
    pulse_reset();
    exmem_branch = 1; exmem_taken = 1;
    #1;
    check("run_resolve_ignored", ctl(), NORMAL);
    tick();
    idle();
    check("run_resolve_flush_cnt", flush_cnt, 0);

    // saturation on the 4-bit instance
    pulse_reset();
    idex_memread = 1; idex_rd = 9; ifid_rs1 = 9;
    for (int i = 0; i < 15; i++) tick();
    check("sat_reach15", stall_cnt4, 15);
    for (int i = 0; i < 5; i++) tick();
    check("sat_hold15", stall_cnt4, 15);
    check("sat_wide20", stall_cnt, 20);
    idle();

    // async reset while waiting on a branch
    pulse_reset();
    idex_branch = 1;
    tick();
    idle();
    #1;
    check("brwait_ctl", ctl(), STALL);
    reset = 1'b1;
    #1;
    check("midreset_ctl", ctl(), NORMAL);
    check("midreset_stall_cnt", stall_cnt, 0);
    reset = 1'b0;
    #1;
    check("postreset_run_ctl", ctl(), NORMAL);
    tick();
    check("postreset_stall_cnt", stall_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
